// File: rtl/fsm_pkg.sv
// Shared encodings for the 4-state counter FSM and its passive checker.
// Holds state/error constants and a helper for the Moore max output.
package fsm_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_A = 2'd0,
    ST_B = 2'd1,
    ST_C = 2'd2,
    ST_D = 2'd3
  } fsm_state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_TRANS = 2'b01;
  localparam logic [1:0] ERR_MAX   = 2'b10;
  localparam logic [1:0] ERR_BOTH  = 2'b11;

  typedef enum logic [1:0] {
    CHK_ARM   = 2'd0,
    CHK_TRACK = 2'd1,
    CHK_FAULT = 2'd2
  } chk_state_e;

  // Moore max output owed by a given state.
  function automatic logic is_max(input logic [ST_W-1:0] s);
    return (s == ST_D);
  endfunction

endpackage

// File: rtl/fsm_ref_step.sv
// Combinational golden model of the counter FSM: one step from (state, en),
// plus the max output of the current state.
module fsm_ref_step
  import fsm_pkg::*;
(
  input  logic [ST_W-1:0] i_state,
  input  logic            i_en,
  output logic [ST_W-1:0] o_next,
  output logic            o_max
);

  // Advance on enable (wrapping D->A), otherwise hold.
  always_comb begin
    o_next = i_state;
    if (i_en) begin
      o_next = i_state + 2'd1;
    end else begin
      o_next = i_state;
    end
    o_max = is_max(i_state);
  end

endmodule

// File: rtl/fsm_checker.sv
// Passive monitor for the 4-state counter FSM: checks transitions and max, counts laps and faults.
// Optional capture of the first faulting transition under macro FSM_CHECKER_CAPTURE_EN.
module fsm_checker
  import fsm_pkg::*;
#(
  parameter int LAP_W    = 8,
  parameter int ERRCNT_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [1:0]          i_state,
  input  logic                i_max,
  input  logic                i_clr,
  output logic [LAP_W-1:0]    o_lap,
  output logic                o_step,
  output logic                o_err,
  output logic [1:0]          o_err_code,
  output logic [ERRCNT_W-1:0] o_err_cnt,
  output logic [1:0]          o_err_prev,
  output logic [1:0]          o_err_state
);

  localparam logic [ERRCNT_W-1:0] CNT_SAT = {ERRCNT_W{1'b1}};

  chk_state_e          r_chk;
  chk_state_e          w_chk_nxt;
  logic [ST_W-1:0]     r_prev_state;
  logic                r_prev_en;
  logic [LAP_W-1:0]    r_lap;
  logic                r_step;
  logic                r_err;
  logic [1:0]          r_err_code;
  logic [ERRCNT_W-1:0] r_err_cnt;

  logic [ST_W-1:0]     w_exp_next;
  logic                w_prev_max;
  logic                w_armed;
  logic                w_trans_bad;
  logic                w_max_bad;
  logic [1:0]          w_code;
  logic                w_fault;
  logic                w_step;
  logic                w_lap_inc;

  fsm_ref_step u_ref (
    .i_state (r_prev_state),
    .i_en    (r_prev_en),
    .o_next  (w_exp_next),
    .o_max   (w_prev_max)
  );

  // Classify the current sample; ARM has no reference so only max is checked.
  always_comb begin
    w_armed     = (r_chk != CHK_ARM);
    w_trans_bad = w_armed && (i_state != w_exp_next);
    w_max_bad   = (i_max != is_max(i_state));
    w_code      = {w_max_bad, w_trans_bad};
    w_fault     = (w_code != ERR_NONE);
    w_step      = w_armed && r_prev_en && (i_state == w_exp_next) && !w_fault;
    w_lap_inc   = w_armed && r_prev_en && w_prev_max && (i_state == ST_A);
  end

  // Checker FSM next state.
  always_comb begin
    w_chk_nxt = r_chk;
    case (r_chk)
      CHK_ARM: begin
        if (w_fault) w_chk_nxt = CHK_FAULT;
        else         w_chk_nxt = CHK_TRACK;
      end
      CHK_TRACK: begin
        if (w_fault) w_chk_nxt = CHK_FAULT;
        else         w_chk_nxt = CHK_TRACK;
      end
      CHK_FAULT: begin
        if (w_fault)    w_chk_nxt = CHK_FAULT;
        else if (i_clr) w_chk_nxt = CHK_TRACK;
        else            w_chk_nxt = CHK_FAULT;
      end
      default: w_chk_nxt = CHK_ARM;
    endcase
  end

  // Reference re-sync every cycle, plus step/lap/fault bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chk        <= CHK_ARM;
      r_prev_state <= 2'd0;
      r_prev_en    <= 1'b0;
      r_lap        <= '0;
      r_step       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_cnt    <= '0;
    end else begin
      r_chk        <= w_chk_nxt;
      r_prev_state <= i_state;
      r_prev_en    <= i_en;
      r_step       <= w_step;
      if (w_lap_inc) r_lap <= r_lap + LAP_W'(1'b1);
      if (w_fault && (r_err_cnt != CNT_SAT)) r_err_cnt <= r_err_cnt + ERRCNT_W'(1'b1);
      // A clear arriving with a fault restarts the code from the new fault alone.
      if (w_fault) begin
        r_err      <= 1'b1;
        r_err_code <= (r_err && !i_clr) ? (r_err_code | w_code) : w_code;
      end else if (i_clr) begin
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
    end
  end

  assign o_lap      = r_lap;
  assign o_step     = r_step;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;
  assign o_err_cnt  = r_err_cnt;

`ifdef FSM_CHECKER_CAPTURE_EN
  logic [1:0] r_cap_prev;
  logic [1:0] r_cap_state;

  // Snapshot the offending transition only when the sticky flag first rises.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cap_prev  <= 2'b00;
      r_cap_state <= 2'b00;
    end else if (w_fault && !r_err) begin
      r_cap_prev  <= r_prev_state;
      r_cap_state <= i_state;
    end else if (i_clr && !w_fault) begin
      r_cap_prev  <= 2'b00;
      r_cap_state <= 2'b00;
    end
  end

  assign o_err_prev  = r_cap_prev;
  assign o_err_state = r_cap_state;
`else
  assign o_err_prev  = 2'b00;
  assign o_err_state = 2'b00;
`endif

endmodule
